mor1kx_true_dpram_be: RTL
=========================

// Module: mor1kx_true_dpram_be
// PURPOSE
//  Single-clock true dual-port RAM with per-byte write enables and selectable read-during-write mode.
//  Has an optional output register stage, a hardware memory-clear sequencer and defined same-address collision handling.
//  Generalised successor of the basic true dual-port RAM; backing store for cache tag/data arrays and the register file.
// PARAMETERS
//  ADDR_WIDTH     8   address bits; DEPTH = 1<<ADDR_WIDTH words
//  DATA_WIDTH     32  word width; must be a multiple of 8; NB = DATA_WIDTH/8 byte lanes
//  RDW_MODE       0   same-port read-during-write: 0 = write-first (new data), 1 = read-first (old data)
//  OUTPUT_REG     0   0 = read latency 1 cycle; 1 = extra output register, latency 2 cycles
//  CLEAR_ON_RESET 1   1 = run the clear sequence after reset; 0 = ready immediately, contents undefined
//  CLEAR_VALUE    0   DATA_WIDTH value written to every word by the clear sequence
// PORTS
//  clk     in   1          clock, all logic on posedge
//  rst_n   in   1          asynchronous active-low reset
//  clear   in   1          request a full-memory clear (sampled in READY only)
//  ready   out  1          1 = ports accepted; 0 = clear in progress
//  en_a    in   1          port A access enable
//  we_a    in   1          port A write (qualified by en_a)
//  be_a    in   NB         port A byte enables (qualified by en_a & we_a)
//  addr_a  in   ADDR_WIDTH port A address
//  din_a   in   DATA_WIDTH port A write data
//  dout_a  out  DATA_WIDTH port A read data
//  valid_a out  1          dout_a holds the result of an accepted port A access
//  en_b/we_b/be_b/addr_b/din_b/dout_b/valid_b: identical for port B
//  collision out 1         same-address conflict seen on an accepted cycle
// BEHAVIOUR
//  Reset (rst_n=0, async):
//  - dout_a/b = 0, valid_a/b = 0, collision = 0, ready = 0, clear counter = 0.
//  - FSM goes to CLEAR if CLEAR_ON_RESET=1, else to READY (ready=1 from the first clk after release).
//  - Memory array is never reset directly.
//  FSM, 2 states:
//  - CLEAR: writes CLEAR_VALUE to address cnt each cycle, cnt += 1. After the write to DEPTH-1, go to READY.
//    ready rises the cycle after that write, so CLEAR lasts exactly DEPTH cycles.
//    en_a/en_b and clear are ignored in CLEAR; valid_a/b stay 0.
//  - READY: ready=1. clear=1 -> CLEAR next cycle, cnt=0; any port access in that same cycle is still performed.
//  Access acceptance: an access is accepted when en_x=1 and ready=1.
//  Write: for each lane i with be_x[i]=1, mem[addr_x][8i+7:8i] <= din_x lane i. we_x=1 with be_x=0 writes nothing but still returns data.
//  Read data:
//  - Every accepted access, read or write, returns data.
//  - OUTPUT_REG=0: dout_x/valid_x update on the clk edge that accepts the access (data visible next cycle).
//  - OUTPUT_REG=1: one further stage.
//  - valid_x = 1 exactly for the cycle(s) the corresponding data is on dout_x. Pipelined back-to-back accesses give contiguous valid.
//  - Not accepted: valid_x = 0 and dout_x holds its previous value.
//  Same-port write data returned:
//  - RDW_MODE=0: merged word (enabled lanes from din_x, others from old contents).
//  - RDW_MODE=1: old contents.
//  Cross-port, same address, both accepted:
//  - Both write: per lane, A wins where be_a=1; B's lanes are written only where be_b=1 & be_a=0.
//  - One port writes: the other port reads the OLD contents regardless of RDW_MODE.
//  - Each writing port's own dout follows RDW_MODE and reflects its own merge (din_x over old), not the other port's lanes.
//  - collision = 1 on the next cycle (registered, 1-cycle pulse) when both accesses are accepted, addr_a==addr_b and we_a|we_b.
//  - Two reads to the same address are not a collision.
//  Reset mid-operation:
//  - Outputs clear immediately and pipelined results are discarded.
//  - A clear in progress restarts from address 0 (CLEAR_ON_RESET=1).
// TESTING
//  T1 reset release, ADDR_WIDTH=4 -> ready=0 for 16 cycles, then 1; reading every address returns CLEAR_VALUE with valid_a=1 one cycle later.
//  T2 old word 0x11223344; A writes addr 5, be=4'b0101, din=0xAABBCCDD -> mem=0x11BB33DD; dout_a=0x11BB33DD (RDW_MODE=0) or 0x11223344 (RDW_MODE=1).
//  T3 word 0; A(be=4'b0011, din=0xFFFFFFFF) and B(be=4'b0110, din=0x12345678) write addr 7 together -> mem=0x0034FFFF; collision=1 for one cycle.
//  T4 A reads addr 3 (old 0xCAFEF00D) while B writes 0x0 there -> dout_a=0xCAFEF00D, collision=1; next A read returns 0x0.
//  T5 OUTPUT_REG=1, reads of addr 0,1,2 on consecutive cycles -> data two cycles after each request; valid_a high for exactly 3 consecutive cycles.
//  T6 clear=1 then rst_n pulsed low at cnt=9 -> outputs 0 at once; after release the clear restarts at 0 and ready rises after DEPTH cycles.

Source files
------------

// File: rtl/mor1kx_true_dpram_be.sv
// True dual-port RAM, per-byte write enables, read-during-write select, hardware clear.
// Read latency 1 cycle (OUTPUT_REG=0) or 2 cycles (OUTPUT_REG=1), fully pipelined.
// No backpressure: ready low during clear sequence, accesses then ignored.
module mor1kx_true_dpram_be #(
   parameter int                    ADDR_WIDTH     = 8,
   parameter int                    DATA_WIDTH     = 32,
   parameter int                    RDW_MODE       = 0,
   parameter int                    OUTPUT_REG     = 0,
   parameter int                    CLEAR_ON_RESET = 1,
   parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clear,
   output logic                    ready,
   input  logic                    en_a,
   input  logic                    we_a,
   input  logic [DATA_WIDTH/8-1:0] be_a,
   input  logic [ADDR_WIDTH-1:0]   addr_a,
   input  logic [DATA_WIDTH-1:0]   din_a,
   output logic [DATA_WIDTH-1:0]   dout_a,
   output logic                    valid_a,
   input  logic                    en_b,
   input  logic                    we_b,
   input  logic [DATA_WIDTH/8-1:0] be_b,
   input  logic [ADDR_WIDTH-1:0]   addr_b,
   input  logic [DATA_WIDTH-1:0]   din_b,
   output logic [DATA_WIDTH-1:0]   dout_b,
   output logic                    valid_b,
   output logic                    collision
);

   localparam int NB    = DATA_WIDTH / 8;
   localparam int DEPTH = 1 << ADDR_WIDTH;

   typedef enum logic {ST_CLEAR, ST_READY} state_t;

   state_t                  state, state_nxt;
   logic [ADDR_WIDTH-1:0]   cnt, cnt_nxt;
   logic [DATA_WIDTH-1:0]   mem [DEPTH];
   logic [DATA_WIDTH-1:0]   old_a, old_b, merged_a, merged_b, rdata_a, rdata_b;
   logic [DATA_WIDTH-1:0]   dout1_a, dout1_b;
   logic                    valid1_a, valid1_b;
   logic                    acc_a, acc_b;

   // ready is registered so it rises one clock after the FSM decides to enter READY
   assign acc_a = en_a & ready;
   assign acc_b = en_b & ready;

   // Clear sequencer: next state and address counter
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         ST_CLEAR: begin
            cnt_nxt = cnt + 1'b1;
            if (cnt == '1)
               state_nxt = ST_READY;
         end
         default: begin
            if (ready && clear) begin
               state_nxt = ST_CLEAR;
               cnt_nxt   = '0;
            end
         end
      endcase
   end

   // FSM state, counter and ready flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
         cnt   <= '0;
         ready <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         ready <= (state_nxt == ST_READY);
      end
   end

   // Old contents and each port's own byte merge (din over old)
   always_comb begin
      old_a    = mem[addr_a];
      old_b    = mem[addr_b];
      merged_a = old_a;
      merged_b = old_b;
      for (int i = 0; i < NB; i++) begin
         if (be_a[i]) merged_a[8*i +: 8] = din_a[8*i +: 8];
         if (be_b[i]) merged_b[8*i +: 8] = din_b[8*i +: 8];
      end
      rdata_a = (RDW_MODE == 0 && we_a) ? merged_a : old_a;
      rdata_b = (RDW_MODE == 0 && we_b) ? merged_b : old_b;
   end

   // Array write: clear sequence, else byte lanes with port A winning same-address lanes
   always_ff @(posedge clk) begin
      if (state == ST_CLEAR) begin
         mem[cnt] <= CLEAR_VALUE;
      end else begin
         for (int i = 0; i < NB; i++) begin
            if (acc_a && we_a && be_a[i])
               mem[addr_a][8*i +: 8] <= din_a[8*i +: 8];
            if (acc_b && we_b && be_b[i] &&
                !(acc_a && we_a && be_a[i] && addr_a == addr_b))
               mem[addr_b][8*i +: 8] <= din_b[8*i +: 8];
         end
      end
   end

   // First read stage and registered collision flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout1_a   <= '0;
         dout1_b   <= '0;
         valid1_a  <= 1'b0;
         valid1_b  <= 1'b0;
         collision <= 1'b0;
      end else begin
         valid1_a  <= acc_a;
         valid1_b  <= acc_b;
         if (acc_a) dout1_a <= rdata_a;
         if (acc_b) dout1_b <= rdata_b;
         collision <= acc_a & acc_b & (addr_a == addr_b) & (we_a | we_b);
      end
   end

   generate
      if (OUTPUT_REG != 0) begin : g_oreg
         logic [DATA_WIDTH-1:0] dout2_a, dout2_b;
         logic                  valid2_a, valid2_b;

         // Optional second output stage, holds data when nothing new arrives
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               dout2_a  <= '0;
               dout2_b  <= '0;
               valid2_a <= 1'b0;
               valid2_b <= 1'b0;
            end else begin
               valid2_a <= valid1_a;
               valid2_b <= valid1_b;
               if (valid1_a) dout2_a <= dout1_a;
               if (valid1_b) dout2_b <= dout1_b;
            end
         end

         assign dout_a  = dout2_a;
         assign dout_b  = dout2_b;
         assign valid_a = valid2_a;
         assign valid_b = valid2_b;
      end else begin : g_noreg
         assign dout_a  = dout1_a;
         assign dout_b  = dout1_b;
         assign valid_a = valid1_a;
         assign valid_b = valid1_b;
      end
   endgenerate

endmodule
